// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter and its parents.
// Direction encoding and a constant clog2 for sizing counters from a modulus.
package mod_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Next-state logic for the modulo up/down counter: clr > load > count > hold.
// Purely combinational; the parent owns every register.
module mod_counter_next
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             next_wrap,
    output logic             load_oor
);

    // One extra bit keeps MODULUS == 2**WIDTH representable as a limit.
    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] val_ext;
    logic [WIDTH:0] nxt_ext;
    logic           unused_msb;

    assign cnt_ext = {1'b0, count};
    assign val_ext = {1'b0, load_val};

    always_comb begin
        nxt_ext   = cnt_ext;
        next_wrap = 1'b0;
        load_oor  = 1'b0;
        if (clr) begin
            nxt_ext = '0;
        end else if (load) begin
            if (val_ext <= MAX) begin
                nxt_ext = val_ext;
            end else begin
                nxt_ext  = MAX;
                load_oor = 1'b1;
            end
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (cnt_ext == MAX) begin
                    nxt_ext   = '0;
                    next_wrap = 1'b1;
                end else begin
                    nxt_ext = cnt_ext + ONE;
                end
            end else begin
                if (cnt_ext == '0) begin
                    nxt_ext   = MAX;
                    next_wrap = 1'b1;
                end else begin
                    nxt_ext = cnt_ext - ONE;
                end
            end
        end
    end

    // Top bit is always zero here since every result is <= MAX.
    assign next_count = nxt_ext[WIDTH-1:0];
    assign unused_msb = nxt_ext[WIDTH];

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with clear, parallel load, terminal count,
// registered wrap pulse and sticky out-of-range load flag.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "mod_updown_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "mod_updown_counter: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             load_oor;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .count      (count_q),
        .up_dn      (up_dn),
        .en         (en),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .next_count (count_d),
        .next_wrap  (wrap_d),
        .load_oor   (load_oor)
    );

    assign load_err_d = clr ? 1'b0 : (load_err_q | load_oor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign tc       = en & ((up_dn == DIR_UP) ? (count_q == TOP) : (count_q == '0));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: a modulo-16 (default) and a modulo-10 instance on shared stimulus.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;

    logic [3:0] c16, c10;
    logic       tc16, tc10, w16, w10, e16, e10;

    int checks = 0;
    int errors = 0;

    mod_updown_counter dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (c16),
        .tc       (tc16),
        .wrap     (w16),
        .load_err (e16)
    );

    mod_updown_counter #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut10 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (c10),
        .tc       (tc10),
        .wrap     (w10),
        .load_err (e10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] val;
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic       err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic e, input logic u,
                          input logic [3:0] v);
        clr = c; load = l; en = e; up_dn = u; load_val = v;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        rst_n = 1'b0;
        #1;
        check("reset_count16", 32'(c16), 0);
        check("reset_count10", 32'(c10), 0);
        check("reset_wrap", 32'({w16, w10}), 0);
        check("reset_err", 32'({e16, e10}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] exp;

        vecs[0]  = '{0, 1, 0, 1, 4'd12, 4'd9, 0, 0, 1};
        vecs[1]  = '{1, 0, 0, 1, 4'd0,  4'd0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 1, 4'd5,  4'd5, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 1, 4'd3,  4'd0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 1, 4'd5,  4'd5, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, 1, 4'd7,  4'd7, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 1, 4'd0,  4'd8, 0, 0, 0};
        vecs[7]  = '{0, 0, 1, 1, 4'd0,  4'd9, 1, 0, 0};
        vecs[8]  = '{0, 0, 1, 1, 4'd0,  4'd0, 0, 1, 0};
        vecs[9]  = '{0, 0, 1, 0, 4'd0,  4'd9, 0, 1, 0};
        vecs[10] = '{0, 1, 0, 1, 4'd15, 4'd9, 0, 0, 1};
        vecs[11] = '{0, 1, 0, 1, 4'd9,  4'd9, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 1, 4'd0,  4'd9, 0, 0, 1};
        vecs[13] = '{1, 0, 0, 1, 4'd0,  4'd0, 0, 0, 0};
        vecs[14] = '{0, 0, 1, 1, 4'd0,  4'd1, 0, 0, 0};

        // Defaults: free-run up through one full wrap.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        #1;
        check("up16_tc_at0", 32'(tc16), 0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            exp = 4'(i % 16);
            check("up16_count", 32'(c16), 32'(exp));
            check("up16_tc", 32'(tc16), 32'(exp == 4'd15));
            check("up16_wrap", 32'(w16), 32'(i == 16));
        end

        // Modulo-10 counting down from 0.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        #1;
        check("dn10_tc_at0", 32'(tc10), 1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = 4'((10 - i) % 10);
            check("dn10_count", 32'(c10), 32'(exp));
            check("dn10_tc", 32'(tc10), 32'(exp == 4'd0));
            check("dn10_wrap", 32'(w10), 32'(i == 1));
        end

        // Table: load / clear / saturation / sticky error on the modulo-10 instance.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].val);
            tick();
            check($sformatf("vec%0d_count", i), 32'(c10), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_tc", i), 32'(tc10), 32'(vecs[i].tc));
            check($sformatf("vec%0d_wrap", i), 32'(w10), 32'(vecs[i].wrap));
            check($sformatf("vec%0d_err", i), 32'(e10), 32'(vecs[i].err));
        end

        // Asynchronous reset mid-cycle with a set error flag.
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        tick();
        tick();
        check("pre_arst_count16", 32'(c16), 6);
        check("pre_arst_count10", 32'(c10), 6);
        check("pre_arst_err10", 32'(e10), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count16", 32'(c16), 0);
        check("arst_count10", 32'(c10), 0);
        check("arst_wrap", 32'({w16, w10}), 0);
        check("arst_err10", 32'(e10), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_arst_count16", 32'(c16), 1);
        check("post_arst_count10", 32'(c10), 1);

        // Hold with en=0, then reverse direction.
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        check("hold_start", 32'(c16), 4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_count", 32'(c16), 4);
            check("hold_tc", 32'(tc16), 0);
            check("hold_wrap", 32'(w16), 0);
        end
        en = 1'b1;
        tick();
        check("dir_up", 32'(c16), 5);
        up_dn = 1'b0;
        tick();
        check("dir_down", 32'(c16), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
